sw_host_bridge: RTL and testbench

Byte-stream host bridge for the Smith-Waterman accelerator. It assembles one reference/read sequence pair from an 8-bit valid/ready byte stream (typically a UART receiver) and issues it as a single job to `SW_core`. It then accepts the core's result and serialises the score, row and column back out as a byte frame. It is the hardware counterpart of the bench host: it drives the core's job-input handshake and terminates its result handshake.

---
 rtl/sw_host_bridge_if.sv | 20 ++
 rtl/sw_host_bridge.sv | 193 +++++++++++++++++++
 tb/tb_sw_host_bridge.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sw_host_bridge_if.sv
// Host-side byte-stream handshake for sw_host_bridge: inbound sequence bytes
// and outbound result bytes, each as an 8-bit valid/ready channel.
interface sw_host_bridge_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/sw_host_bridge.sv
// Byte-stream host bridge: assembles one ref/read job for SW_core and returns
// score/row/col as a byte frame. Optional feature macro: SW_BRIDGE_CHECKSUM_EN.
module sw_host_bridge #(
  parameter int REF_LENGTH      = 128,
  parameter int READ_LENGTH     = 128,
  parameter int REF_MAX_LENGTH  = 256,
  parameter int READ_MAX_LENGTH = 256,
  parameter int SCORE_BW        = 10
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  sw_host_bridge_if.slave                      host,
  input  logic                                 core_o_ready,
  output logic                                 core_i_valid,
  output logic [2*REF_MAX_LENGTH-1:0]          core_seq_ref,
  output logic [2*READ_MAX_LENGTH-1:0]         core_seq_read,
  output logic [$clog2(REF_MAX_LENGTH):0]      core_ref_len,
  output logic [$clog2(READ_MAX_LENGTH):0]     core_read_len,
  output logic                                 core_i_ready,
  input  logic                                 core_o_valid,
  input  logic [SCORE_BW-1:0]                  core_score,
  input  logic [$clog2(READ_MAX_LENGTH)-1:0]   core_row,
  input  logic [$clog2(REF_MAX_LENGTH)-1:0]    core_col
);

  localparam int REF_W    = 2 * REF_LENGTH;
  localparam int READ_W   = 2 * READ_LENGTH;
  localparam int SREF_W   = 2 * REF_MAX_LENGTH;
  localparam int SREAD_W  = 2 * READ_MAX_LENGTH;
  localparam int REF_PAD  = 2 * (REF_MAX_LENGTH - REF_LENGTH);
  localparam int READ_PAD = 2 * (READ_MAX_LENGTH - READ_LENGTH);
  localparam int RLEN_W   = $clog2(REF_MAX_LENGTH) + 1;
  localparam int DLEN_W   = $clog2(READ_MAX_LENGTH) + 1;
`ifdef SW_BRIDGE_CHECKSUM_EN
  localparam int FRAME_BYTES = 7;
`else
  localparam int FRAME_BYTES = 6;
`endif
  localparam int TX_W = 8 * FRAME_BYTES;

  localparam logic [15:0] REF_LAST  = 16'(REF_LENGTH / 4 - 1);
  localparam logic [15:0] READ_LAST = 16'(READ_LENGTH / 4 - 1);
  localparam logic [15:0] TX_LAST   = 16'(FRAME_BYTES - 1);

  typedef enum logic [2:0] {
    RX_REF, RX_READ, RX_CSUM, WAIT_CORE, ISSUE, WAIT_RES, TX
  } state_t;

  state_t              state;
  logic [15:0]         byte_cnt;
  logic [REF_W-1:0]    ref_buf;
  logic [READ_W-1:0]   read_buf;
  logic [TX_W-1:0]     tx_buf;
  logic [47:0]         res_word;
  logic [TX_W-1:0]     res_frame;
`ifdef SW_BRIDGE_CHECKSUM_EN
  localparam logic [TX_W-1:0] ERR_FRAME = 56'h80_00_00_00_00_00_80;
  logic [7:0]          csum;
`endif

  always_comb begin
    res_word = {16'(signed'(core_score)), 16'(core_row), 16'(core_col)};
`ifdef SW_BRIDGE_CHECKSUM_EN
    res_frame = {res_word, res_word[47:40] ^ res_word[39:32] ^ res_word[31:24]
                         ^ res_word[23:16] ^ res_word[15:8]  ^ res_word[7:0]};
`else
    res_frame = res_word;
`endif
  end

  // Outbound byte is always the top byte of the shifting frame register.
  assign host.out_data = tx_buf[TX_W-1 -: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RX_REF;
      byte_cnt      <= '0;
      ref_buf       <= '0;
      read_buf      <= '0;
      tx_buf        <= '0;
`ifdef SW_BRIDGE_CHECKSUM_EN
      csum          <= '0;
`endif
      host.in_ready  <= 1'b0;
      host.out_valid <= 1'b0;
      core_i_valid   <= 1'b0;
      core_i_ready   <= 1'b0;
      core_seq_ref   <= '0;
      core_seq_read  <= '0;
      core_ref_len   <= '0;
      core_read_len  <= '0;
    end else begin
      core_i_valid  <= 1'b0;
      core_seq_ref  <= '0;
      core_seq_read <= '0;
      core_ref_len  <= '0;
      core_read_len <= '0;
      case (state)
        RX_REF: begin
          host.in_ready <= 1'b1;
          if (host.in_valid && host.in_ready) begin
            ref_buf <= {ref_buf[REF_W-9:0], host.in_data};
`ifdef SW_BRIDGE_CHECKSUM_EN
            csum <= csum ^ host.in_data;
`endif
            if (byte_cnt == REF_LAST) begin
              byte_cnt <= '0;
              state    <= RX_READ;
            end else begin
              byte_cnt <= byte_cnt + 16'd1;
            end
          end
        end
        RX_READ: begin
          host.in_ready <= 1'b1;
          if (host.in_valid && host.in_ready) begin
            read_buf <= {read_buf[READ_W-9:0], host.in_data};
            if (byte_cnt == READ_LAST) begin
              byte_cnt <= '0;
`ifdef SW_BRIDGE_CHECKSUM_EN
              csum  <= csum ^ host.in_data;
              state <= RX_CSUM;
`else
              host.in_ready <= 1'b0;
              state         <= WAIT_CORE;
`endif
            end else begin
              byte_cnt <= byte_cnt + 16'd1;
`ifdef SW_BRIDGE_CHECKSUM_EN
              csum <= csum ^ host.in_data;
`endif
            end
          end
        end
        RX_CSUM: begin
`ifdef SW_BRIDGE_CHECKSUM_EN
          if (host.in_valid && host.in_ready) begin
            host.in_ready <= 1'b0;
            csum          <= '0;
            if (host.in_data == csum) begin
              state <= WAIT_CORE;
            end else begin
              // Bad checksum: skip the core entirely and report the error frame.
              tx_buf         <= ERR_FRAME;
              host.out_valid <= 1'b1;
              state          <= TX;
            end
          end
`else
          state <= RX_REF;
`endif
        end
        WAIT_CORE: begin
          if (core_o_ready) begin
            core_i_valid  <= 1'b1;
            core_seq_ref  <= SREF_W'(ref_buf) << REF_PAD;
            core_seq_read <= SREAD_W'(read_buf) << READ_PAD;
            core_ref_len  <= RLEN_W'(REF_LENGTH);
            core_read_len <= DLEN_W'(READ_LENGTH);
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          core_i_ready <= 1'b1;
          state        <= WAIT_RES;
        end
        WAIT_RES: begin
          if (core_o_valid) begin
            tx_buf         <= res_frame;
            core_i_ready   <= 1'b0;
            host.out_valid <= 1'b1;
            state          <= TX;
          end
        end
        TX: begin
          if (host.out_ready) begin
            tx_buf <= tx_buf << 8;
            if (byte_cnt == TX_LAST) begin
              byte_cnt       <= '0;
              host.out_valid <= 1'b0;
              host.in_ready  <= 1'b1;
              state          <= RX_REF;
            end else begin
              byte_cnt <= byte_cnt + 16'd1;
            end
          end
        end
        default: state <= RX_REF;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_host_bridge.sv
// Directed bench for sw_host_bridge (128/128 bases into a 256/256 core).
module tb_sw_host_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sw_host_bridge_if host ();

  logic         core_o_ready;
  logic         core_i_valid;
  logic [511:0] core_seq_ref;
  logic [511:0] core_seq_read;
  logic [8:0]   core_ref_len;
  logic [8:0]   core_read_len;
  logic         core_i_ready;
  logic         core_o_valid;
  logic [9:0]   core_score;
  logic [7:0]   core_row;
  logic [7:0]   core_col;

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  sw_host_bridge #(
    .REF_LENGTH(128), .READ_LENGTH(128),
    .REF_MAX_LENGTH(256), .READ_MAX_LENGTH(256), .SCORE_BW(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .host(host),
    .core_o_ready(core_o_ready), .core_i_valid(core_i_valid),
    .core_seq_ref(core_seq_ref), .core_seq_read(core_seq_read),
    .core_ref_len(core_ref_len), .core_read_len(core_read_len),
    .core_i_ready(core_i_ready), .core_o_valid(core_o_valid),
    .core_score(core_score), .core_row(core_row), .core_col(core_col)
  );

  always @(negedge clk) if (core_i_valid) pulses++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_wide(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    host.in_data  = b;
    host.in_valid = 1'b1;
    while (!host.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("in_ready_timeout", 64'(host.in_ready), 64'd1);
    @(negedge clk);
    host.in_valid = 1'b0;
  endtask

  task automatic recv_frame(input logic [55:0] exp, input int nbytes, input bit toggle);
    for (int i = 0; i < nbytes; i++) begin
      if (toggle) begin
        host.out_ready = 1'b0;
        check("hold_valid", 64'(host.out_valid), 64'd1);
        check("hold_data", 64'(host.out_data), 64'(exp[8*(nbytes-1-i) +: 8]));
        @(negedge clk);
      end
      host.out_ready = 1'b1;
      check("tx_valid", 64'(host.out_valid), 64'd1);
      check("tx_data", 64'(host.out_data), 64'(exp[8*(nbytes-1-i) +: 8]));
      @(negedge clk);
    end
    check("tx_done", 64'(host.out_valid), 64'd0);
  endtask

  task automatic run_job(input logic [7:0] rb, input logic [7:0] qb, input logic [7:0] inc,
                         input int busy, input bit bad_csum, input logic [9:0] sc,
                         input logic [7:0] row, input logic [7:0] col,
                         input logic [47:0] exp48, input bit toggle);
    logic [511:0] er;
    logic [511:0] eq;
    logic [7:0]   cs;
    logic [7:0]   b;
    logic [55:0]  ef;
    int           nb;
    int           p0;
    p0 = pulses;
    er = '0;
    eq = '0;
    cs = '0;
    core_o_ready = (busy == 0);
    for (int k = 0; k < 32; k++) begin
      b = 8'(rb + k * inc);
      er[511-8*k -: 8] = b;
      cs ^= b;
      send_byte(b);
    end
    for (int k = 0; k < 32; k++) begin
      b = 8'(qb + k * inc);
      eq[511-8*k -: 8] = b;
      cs ^= b;
      send_byte(b);
    end
`ifdef SW_BRIDGE_CHECKSUM_EN
    send_byte(bad_csum ? ~cs : cs);
    if (bad_csum) begin
      check("err_no_issue", 64'(core_i_valid), 64'd0);
      recv_frame(56'h80_00_00_00_00_00_80, 7, 1'b0);
      check("err_pulses", 64'(pulses), 64'(p0));
      return;
    end
    ef = {exp48, exp48[47:40] ^ exp48[39:32] ^ exp48[31:24] ^ exp48[23:16] ^ exp48[15:8] ^ exp48[7:0]};
    nb = 7;
`else
    ef = {8'h00, exp48};
    nb = 6;
`endif
    check("rx_closed", 64'(host.in_ready), 64'd0);
    check("no_early_issue", 64'(core_i_valid), 64'd0);
    for (int i = 0; i < busy; i++) begin
      @(negedge clk);
      check("busy_in_ready", 64'(host.in_ready), 64'd0);
      check("busy_no_issue", 64'(core_i_valid), 64'd0);
    end
    core_o_ready = 1'b1;
    @(negedge clk);
    check("issue_valid", 64'(core_i_valid), 64'd1);
    check_wide("seq_ref", core_seq_ref, er);
    check_wide("seq_read", core_seq_read, eq);
    check("ref_len", 64'(core_ref_len), 64'd128);
    check("read_len", 64'(core_read_len), 64'd128);
    @(negedge clk);
    check("issue_once", 64'(core_i_valid), 64'd0);
    check_wide("seq_ref_idle", core_seq_ref, '0);
    check("res_ready", 64'(core_i_ready), 64'd1);
    @(negedge clk);
    check("res_ready_hold", 64'(core_i_ready), 64'd1);
    core_o_valid = 1'b1;
    core_score   = sc;
    core_row     = row;
    core_col     = col;
    @(negedge clk);
    core_o_valid = 1'b0;
    check("res_ready_drop", 64'(core_i_ready), 64'd0);
    recv_frame(ef, nb, toggle);
    check("rx_reopen", 64'(host.in_ready), 64'd1);
    check("job_pulses", 64'(pulses), 64'(p0 + 1));
  endtask

  initial begin
    int p_before;
    host.in_data   = '0;
    host.in_valid  = 1'b0;
    host.out_ready = 1'b1;
    core_o_ready   = 1'b1;
    core_o_valid   = 1'b0;
    core_score     = '0;
    core_row       = '0;
    core_col       = '0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(host.in_ready), 64'd0);
    check("rst_out_valid", 64'(host.out_valid), 64'd0);
    check("rst_out_data", 64'(host.out_data), 64'd0);
    check("rst_i_valid", 64'(core_i_valid), 64'd0);
    check("rst_i_ready", 64'(core_i_ready), 64'd0);
    check_wide("rst_seq_ref", core_seq_ref, '0);
    check_wide("rst_seq_read", core_seq_read, '0);
    check("rst_lens", 64'({core_ref_len, core_read_len}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", 64'(host.in_ready), 64'd1);

    // Single job: all-0x1B sequences, positive score.
    run_job(8'h1B, 8'h1B, 8'd0, 0, 1'b0, 10'd256, 8'd127, 8'd127, 48'h0100_007F_007F, 1'b0);

    // A stray result strobe outside WAIT_RES must not disturb the next job.
    core_o_valid = 1'b1;
    core_score   = 10'h155;
    @(negedge clk);
    core_o_valid = 1'b0;
    check("stray_no_tx", 64'(host.out_valid), 64'd0);

    // Negative score with out_ready toggling.
    run_job(8'h40, 8'h90, 8'd1, 0, 1'b0, 10'h3FD, 8'd5, 8'd9, 48'hFFFD_0005_0009, 1'b1);

    // Busy core for 50 cycles; most negative score, max column.
    run_job(8'hC3, 8'h3C, 8'd7, 50, 1'b0, 10'h200, 8'd0, 8'd255, 48'hFE00_0000_00FF, 1'b0);

    // Reset after 20 ref bytes, then a fresh job.
    p_before = pulses;
    for (int k = 0; k < 20; k++) send_byte(8'hEE);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 64'(host.in_ready), 64'd0);
    check("mid_rst_i_valid", 64'(core_i_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_reopen", 64'(host.in_ready), 64'd1);
    run_job(8'h05, 8'hA0, 8'd3, 0, 1'b0, 10'd0, 8'd0, 8'd0, 48'h0000_0000_0000, 1'b0);
    check("mid_rst_pulses", 64'(pulses), 64'(p_before + 1));

`ifdef SW_BRIDGE_CHECKSUM_EN
    run_job(8'h1B, 8'h1B, 8'd0, 0, 1'b1, 10'd0, 8'd0, 8'd0, 48'h0, 1'b0);
    run_job(8'h1B, 8'h1B, 8'd0, 0, 1'b0, 10'd256, 8'd127, 8'd127, 48'h0100_007F_007F, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
